// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared CPU types for the prefetch/execution memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_INSTR = 2'd1,
    GRANT_DATA  = 2'd2
  } arb_state_e;

  typedef logic [19:1] word_addr_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (prefetch/execution) arbiter onto one shared memory bus.
// Data wins in IDLE unless the instruction port has been starved for STARVE_LIMIT grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_m_access,
  input  word_addr_t  instr_m_addr,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic        data_m_access,
  input  word_addr_t  data_m_addr,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic [15:0] data_m_data_out,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  output logic        q_m_access,
  output word_addr_t  q_m_addr,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic [15:0] q_m_data_out,
  input  logic        q_m_ack,
  input  logic [15:0] q_m_data_in
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!instr_m_access) starve_cnt_d = '0;
        if (instr_m_access && (starve_cnt_q == STARVE_MAX || !data_m_access)) begin
          state_d      = GRANT_INSTR;
          starve_cnt_d = '0;
        end else if (data_m_access) begin
          state_d = GRANT_DATA;
          // Count only grants that actually made the prefetch wait.
          if (instr_m_access && starve_cnt_q != STARVE_MAX)
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
      end
      GRANT_INSTR: if (!instr_m_access || q_m_ack) state_d = IDLE;
      GRANT_DATA:  if (!data_m_access || q_m_ack) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    q_m_access   = 1'b0;
    q_m_addr     = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    q_m_data_out = 16'h0000;
    instr_m_ack  = 1'b0;
    data_m_ack   = 1'b0;
    unique case (state_q)
      GRANT_INSTR: begin
        q_m_access  = instr_m_access & ~q_m_ack;
        q_m_addr    = instr_m_addr;
        q_m_bytesel = 2'b11;
        instr_m_ack = q_m_ack;
      end
      GRANT_DATA: begin
        q_m_access   = data_m_access & ~q_m_ack;
        q_m_addr     = data_m_addr;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        q_m_data_out = data_m_data_out;
        data_m_ack   = q_m_ack;
      end
      default: ;
    endcase
  end

  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while an instruction request waits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_m_access  input  1  prefetch read request, held until ack.
REQ-005 instr_m_addr  input  19 ([19:1])  prefetch word address.
REQ-006 instr_m_ack  output  1  completion strobe to prefetch.
REQ-007 instr_m_data_in  output  16  read data to prefetch.
REQ-008 data_m_access  input  1  execution-unit request, held until ack.
REQ-009 data_m_addr  input  19 ([19:1])  execution-unit word address.
REQ-010 data_m_wr_en  input  1  1 = write, 0 = read.
REQ-011 data_m_bytesel  input  2  byte lanes (bit0 = [7:0], bit1 = [15:8]).
REQ-012 data_m_data_out  input  16  write data.
REQ-013 data_m_ack  output  1  completion strobe to execution unit.
REQ-014 data_m_data_in  output  16  read data to execution unit.
REQ-015 q_m_access  output  1  shared bus request.
REQ-016 q_m_addr  output  19 ([19:1])  shared bus address.
REQ-017 q_m_wr_en, q_m_bytesel, q_m_data_out  output  1/2/16  shared bus write control and data.
REQ-018 q_m_ack  input  1  shared bus completion.
REQ-019 q_m_data_in  input  16  shared bus read data.

Function
REQ-020 Three-state FSM: IDLE, GRANT_INSTR, GRANT_DATA.
REQ-021 Arbitration occurs only in IDLE; the grant state is registered, so q_m_access asserts one cycle after the winning request is sampled.
REQ-022 Priority in IDLE is data over instruction, except when starve_cnt == STARVE_LIMIT and instr_m_access = 1, in which case instruction wins.
REQ-023 The FSM SHALL remain in the granted state until q_m_ack; the ack cycle transitions to IDLE, so there is exactly one idle cycle between transactions.
REQ-024 q_m_access = granted requester's access AND NOT q_m_ack; the output is 0 in IDLE.
REQ-025 q_m_addr, q_m_wr_en, q_m_bytesel and q_m_data_out are muxed combinationally from the granted requester; in IDLE and GRANT_INSTR, wr_en, bytesel and data_out are 0, and the instruction grant drives bytesel 2'b11.
REQ-026 q_m_ack is routed combinationally to the granted requester's ack only; the other ack stays 0.
REQ-027 q_m_data_in is fanned out unregistered to both *_data_in ports.
REQ-028 If the granted requester drops access before q_m_ack, the FSM returns to IDLE next cycle with no ack issued.
REQ-029 A q_m_ack received in IDLE is ignored: no requester ack, no state change.
REQ-030 starve_cnt width is $clog2(STARVE_LIMIT+1).
REQ-031 starve_cnt increments, saturating at STARVE_LIMIT, on each data grant made while instr_m_access = 1.
REQ-032 starve_cnt clears on any instruction grant, and in IDLE when instr_m_access = 0.
REQ-033 When both requests arrive in the same cycle and starve_cnt < STARVE_LIMIT, the data port is granted.

Reset
REQ-034 Reset SHALL force IDLE and starve_cnt = 0, giving q_m_access = 0 and both acks = 0 in the following cycle.
REQ-035 Reset asserted mid-transaction abandons the grant; any later q_m_ack is handled per REQ-029.
REQ-036 Reset has priority over every other state update.

Structure
REQ-037 The FSM state enum and the 19-bit word-address type belong in the shared CPU package; STARVE_LIMIT remains a module parameter.
REQ-038 There is no sub-module: one FSM register block, one counter, and combinational muxes.

Verification
REQ-039 Instruction-only: instr_m_access = 1, addr = 19'h7FFF8, ack after 3 cycles -> q_m_access one cycle later with addr 19'h7FFF8, bytesel 2'b11; instr_m_ack pulses once; data_m_ack stays 0.
REQ-040 Simultaneous requests with starve_cnt = 0 -> data served first with wr_en and bytesel 2'b01 forwarded; one idle cycle; instruction served next.
REQ-041 Data held continuously with instruction pending, STARVE_LIMIT = 4 -> four data grants, fifth grant goes to instruction, starve_cnt returns to 0.
REQ-042 Instruction drops access two cycles into its grant -> q_m_access falls the same cycle, FSM returns to IDLE, pending data granted the cycle after.
REQ-043 Reset pulsed mid-data-grant, then q_m_ack asserted -> no ack to either port; q_m_access = 0 until a new request arrives.
REQ-044 q_m_data_in = 16'hA55A during an instruction ack -> both data_in ports show 16'hA55A; only instr_m_ack = 1.
